// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared constants, FSM state types and an address range
//               helper for the handshaked register file.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int NREGS_DEF = 16;   // default register count
    localparam int DW_DEF    = 16;   // default data width
    localparam int AW        = 4;    // address width of every register index port

    // Write-port handshake states
    typedef enum logic [0:0] {
        W_IDLE = 1'b0,
        W_ACK  = 1'b1
    } wr_state_t;

    // Read-port handshake states
    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_ACK  = 2'd2
    } rd_state_t;

    // An index is backed by real storage only when it is below the register count.
    function automatic logic addr_in_range(input logic [AW-1:0] a, input int n);
        return (int'(a) < n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : regfile_scoreboard
// Description : One busy bit per register. Write commits clear, reservations
//               set; a reservation landing on the same edge as a commit to the
//               same register wins. Reserving a busy register is refused and
//               latches a sticky error.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               i_rsv_en/addr   - reservation strobe and target
//               i_clr_en/addr   - write commit clearing a busy bit
//               o_busy_next     - busy vector as it will be after this edge
//               o_rsv_ok        - reservation of i_rsv_addr would be accepted
//               o_rsv_err       - sticky: a reservation hit a busy register
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS    = NREGS_DEF,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_rsv_en,
    input  logic [AW-1:0]    i_rsv_addr,
    input  logic             i_clr_en,
    input  logic [AW-1:0]    i_clr_addr,
    output logic [NREGS-1:0] o_busy_next,
    output logic             o_rsv_ok,
    output logic             o_rsv_err
);

    logic [NREGS-1:0] r_busy;
    logic             r_rsv_err;

    logic [NREGS-1:0] w_clr_mask;
    logic [NREGS-1:0] w_set_mask;
    logic [NREGS-1:0] w_busy_cleared;
    logic [NREGS-1:0] w_busy_next;
    logic             w_rsv_legal;
    logic             w_rsv_ok;
    logic             w_rsv_hit;

    always_comb begin
        w_clr_mask = '0;
        w_set_mask = '0;

        w_rsv_legal = addr_in_range(i_rsv_addr, NREGS) &&
                      !(ZERO_REG && (i_rsv_addr == '0));

        if (i_clr_en && addr_in_range(i_clr_addr, NREGS)) begin
            w_clr_mask[i_clr_addr] = 1'b1;
        end

        // Judge the reservation against the busy state after this edge's
        // commit, so a commit and a fresh reservation to the same register
        // hand the bit straight over to the new writer.
        w_busy_cleared = r_busy & ~w_clr_mask;

        w_rsv_ok  = w_rsv_legal && !w_busy_cleared[i_rsv_addr];
        w_rsv_hit = w_rsv_legal &&  w_busy_cleared[i_rsv_addr];

        if (i_rsv_en && w_rsv_ok) begin
            w_set_mask[i_rsv_addr] = 1'b1;
        end

        w_busy_next = w_busy_cleared | w_set_mask;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy    <= '0;
            r_rsv_err <= 1'b0;
        end else begin
            r_busy <= w_busy_next;
            if (i_rsv_en && w_rsv_hit) begin
                r_rsv_err <= 1'b1;
            end
        end
    end

    assign o_busy_next = w_busy_next;
    assign o_rsv_ok    = w_rsv_ok;
    assign o_rsv_err   = r_rsv_err;

endmodule
`default_nettype wire

// File: rtl/regfile_hs.sv
`default_nettype none
// ============================================================================
// Module      : regfile_hs
// Description : Architectural register file with a 4-phase write port for
//               writeback, a 4-phase dual-operand read port that stalls on
//               busy registers, and a reservation scoreboard.
// Ports       : clk, rst                  - clock, synchronous active-high reset
//               write_en/addr/data, reg_ack - write request / acknowledge
//               read_req, rs1, rs2          - operand read request
//               read_ack, rdata1, rdata2    - read acknowledge and operands
//               rsv_en, rsv_addr            - reserve a register (strobe)
//               rsv_ok                      - reservation would be accepted
//               rsv_err                     - sticky double-reservation flag
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_hs
    import regfile_pkg::*;
#(
    parameter int NREGS    = NREGS_DEF,
    parameter int DW       = DW_DEF,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          write_en,
    input  logic [AW-1:0] write_addr,
    input  logic [DW-1:0] write_data,
    output logic          reg_ack,
    input  logic          read_req,
    input  logic [AW-1:0] rs1,
    input  logic [AW-1:0] rs2,
    output logic          read_ack,
    output logic [DW-1:0] rdata1,
    output logic [DW-1:0] rdata2,
    input  logic          rsv_en,
    input  logic [AW-1:0] rsv_addr,
    output logic          rsv_ok,
    output logic          rsv_err
);

    logic [DW-1:0]    r_regs [NREGS];
    wr_state_t        r_wr_state;
    rd_state_t        r_rd_state;
    logic             r_reg_ack;
    logic             r_read_ack;
    logic [DW-1:0]    r_rdata1;
    logic [DW-1:0]    r_rdata2;

    logic             w_wr_commit;
    logic             w_wr_keep;
    logic [NREGS-1:0] w_busy_next;
    logic             w_rs_busy;
    logic [DW-1:0]    w_rd1;
    logic [DW-1:0]    w_rd2;

    // A write commits on the edge the write FSM leaves W_IDLE; it is still
    // acknowledged when the target is reg 0 or out of range, just not stored.
    assign w_wr_commit = (r_wr_state == W_IDLE) && write_en;
    assign w_wr_keep   = w_wr_commit &&
                         addr_in_range(write_addr, NREGS) &&
                         !(ZERO_REG && (write_addr == '0));

    regfile_scoreboard #(
        .NREGS    (NREGS),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .i_rsv_en    (rsv_en),
        .i_rsv_addr  (rsv_addr),
        .i_clr_en    (w_wr_keep),
        .i_clr_addr  (write_addr),
        .o_busy_next (w_busy_next),
        .o_rsv_ok    (rsv_ok),
        .o_rsv_err   (rsv_err)
    );

    // Operand selection. Out-of-range and hard-wired-zero indices read 0 and
    // are never busy. A write committing on the capture edge is forwarded so
    // the read that was waiting on it gets the new value.
    always_comb begin
        w_rd1 = '0;
        w_rd2 = '0;
        if (addr_in_range(rs1, NREGS) && !(ZERO_REG && (rs1 == '0))) begin
            w_rd1 = (w_wr_keep && (write_addr == rs1)) ? write_data : r_regs[rs1];
        end
        if (addr_in_range(rs2, NREGS) && !(ZERO_REG && (rs2 == '0))) begin
            w_rd2 = (w_wr_keep && (write_addr == rs2)) ? write_data : r_regs[rs2];
        end
        // Post-update busy state: includes this edge's commit clear and any
        // reservation accepted on this same edge.
        w_rs_busy = (addr_in_range(rs1, NREGS) && w_busy_next[rs1]) ||
                    (addr_in_range(rs2, NREGS) && w_busy_next[rs2]);
    end

    // Write handshake and register storage
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_state <= W_IDLE;
            r_reg_ack  <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            case (r_wr_state)
                W_IDLE: begin
                    if (write_en) begin
                        if (w_wr_keep) begin
                            r_regs[write_addr] <= write_data;
                        end
                        r_reg_ack  <= 1'b1;
                        r_wr_state <= W_ACK;
                    end
                end
                W_ACK: begin
                    if (!write_en) begin
                        r_reg_ack  <= 1'b0;
                        r_wr_state <= W_IDLE;
                    end
                end
                default: begin
                    r_reg_ack  <= 1'b0;
                    r_wr_state <= W_IDLE;
                end
            endcase
        end
    end

    // Read handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_state <= R_IDLE;
            r_read_ack <= 1'b0;
            r_rdata1   <= '0;
            r_rdata2   <= '0;
        end else begin
            case (r_rd_state)
                R_IDLE: begin
                    if (read_req) begin
                        r_rd_state <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    if (!read_req) begin
                        // Requester withdrew before we answered
                        r_rd_state <= R_IDLE;
                    end else if (!w_rs_busy) begin
                        r_rdata1   <= w_rd1;
                        r_rdata2   <= w_rd2;
                        r_read_ack <= 1'b1;
                        r_rd_state <= R_ACK;
                    end
                end
                R_ACK: begin
                    if (!read_req) begin
                        r_read_ack <= 1'b0;
                        r_rd_state <= R_IDLE;
                    end
                end
                default: begin
                    r_read_ack <= 1'b0;
                    r_rd_state <= R_IDLE;
                end
            endcase
        end
    end

    assign reg_ack  = r_reg_ack;
    assign read_ack = r_read_ack;
    assign rdata1   = r_rdata1;
    assign rdata2   = r_rdata2;

endmodule
`default_nettype wire
